rx_dfe_slicer: RTL and testbench

- Receive-side counterpart of the behavioural transmitter/channel model, which drives bit-weighted impulse sums onto the analog line.
- Takes signed ADC samples of that line and removes post-cursor ISI using previously decided bits and programmable tap weights.
- Slices each equalized sample to a bit and emits it with a valid strobe.
- Sits between the ADC sample path and the PRBS checker/digital back end; also counts low-margin decisions for link bring-up.

---
 rtl/rx_dfe_pack.sv | 22 ++
 rtl/rx_dfe_isi_sum.sv | 27 ++
 rtl/rx_dfe_slicer.sv | 153 +++++++++++++++
 tb/tb_rx_dfe_slicer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_dfe_pack.sv
// Shared types and constants for the receive DFE slicer.
// Holds the FSM state encoding, the accumulator width function,
// the tap address map and the default number of taps.
package rx_dfe_pack;

  localparam int unsigned DEFAULT_N_TAPS = 8;
  localparam int unsigned OFFSET_ADDR    = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } dfe_state_e;

  // Width that holds adc - offset - sum(+-taps) without overflow.
  function automatic int unsigned acc_width(input int unsigned adc_w,
                                            input int unsigned tap_w,
                                            input int unsigned n_taps);
    return ((adc_w > tap_w) ? adc_w : tap_w) + $clog2(n_taps + 2) + 1;
  endfunction

endpackage

// File: rtl/rx_dfe_isi_sum.sv
// Combinational post-cursor ISI estimate.
// Ports:
//   hist  decided-bit history, hist[0] = most recent decision
//   taps  signed post-cursor weights, taps[k] pairs with hist[k]
//   isi   signed feedback term: sum of (hist[k] ? +taps[k] : -taps[k])
module rx_dfe_isi_sum
  import rx_dfe_pack::*;
#(
  parameter int unsigned N_TAPS    = DEFAULT_N_TAPS,
  parameter int unsigned TAP_WIDTH = 10,
  parameter int unsigned ACC_WIDTH = acc_width(8, TAP_WIDTH, N_TAPS)
) (
  input  logic [N_TAPS-1:0]           hist,
  input  logic signed [TAP_WIDTH-1:0] taps [N_TAPS],
  output logic signed [ACC_WIDTH-1:0] isi
);

  // Each decided bit maps to a +1/-1 symbol weighting its tap.
  always_comb begin
    isi = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      if (hist[k]) isi = isi + ACC_WIDTH'(taps[k]);
      else         isi = isi - ACC_WIDTH'(taps[k]);
    end
  end

endmodule

// File: rtl/rx_dfe_slicer.sv
// Decision-feedback equalizer and slicer for the ADC sample path.
// Ports:
//   clk_i, rstb_i          sample clock, async active-low reset
//   en_i                   equalizer enable (low forces IDLE)
//   adc_valid_i/adc_data_i signed sample strobe and data
//   tap_wr_i/addr/data     tap register write (addr 0 = slicer offset)
//   margin_i               unsigned low-margin threshold
//   bit_valid_o/bit_o/eq_o registered decision and equalized value
//   state_o                IDLE=0, WARMUP=1, RUN=2
//   lowmargin_cnt_o        saturating count of |eq| < margin_i
module rx_dfe_slicer
  import rx_dfe_pack::*;
#(
  parameter  int unsigned N_TAPS    = DEFAULT_N_TAPS,
  parameter  int unsigned ADC_WIDTH = 8,
  parameter  int unsigned TAP_WIDTH = 10,
  parameter  int unsigned CNT_WIDTH = 16,
  localparam int unsigned ACC_WIDTH = acc_width(ADC_WIDTH, TAP_WIDTH, N_TAPS),
  localparam int unsigned ADDR_W    = $clog2(N_TAPS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rstb_i,
  input  logic                        en_i,
  input  logic                        adc_valid_i,
  input  logic signed [ADC_WIDTH-1:0] adc_data_i,
  input  logic                        tap_wr_i,
  input  logic [ADDR_W-1:0]           tap_addr_i,
  input  logic signed [TAP_WIDTH-1:0] tap_data_i,
  input  logic [TAP_WIDTH-2:0]        margin_i,
  output logic                        bit_valid_o,
  output logic                        bit_o,
  output logic signed [ACC_WIDTH-1:0] eq_o,
  output logic [1:0]                  state_o,
  output logic [CNT_WIDTH-1:0]        lowmargin_cnt_o
);

  localparam int unsigned WARM_W = $clog2(N_TAPS + 1);

  dfe_state_e                  state_q, state_d;
  logic signed [TAP_WIDTH-1:0] offset_q;
  logic signed [TAP_WIDTH-1:0] post_q [N_TAPS];
  logic [N_TAPS-1:0]           hist_q;
  logic [WARM_W-1:0]           warm_q;
  logic                        bit_valid_q, bit_q;
  logic signed [ACC_WIDTH-1:0] eq_q;
  logic [CNT_WIDTH-1:0]        cnt_q;

  logic signed [ACC_WIDTH-1:0] isi_c, eq_c;
  logic [ACC_WIDTH-1:0]        eq_abs_c;
  logic                        bit_c, low_c;
  logic                        accept_c, emit_c, clear_c;

  // Feedback term from decided-bit history.
  rx_dfe_isi_sum #(
    .N_TAPS    (N_TAPS),
    .TAP_WIDTH (TAP_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_isi_sum (
    .hist (hist_q),
    .taps (post_q),
    .isi  (isi_c)
  );

  // Equalize, slice and measure margin in the sample cycle.
  always_comb begin
    eq_c     = ACC_WIDTH'(adc_data_i) - ACC_WIDTH'(offset_q) - isi_c;
    bit_c    = ~eq_c[ACC_WIDTH-1];
    eq_abs_c = eq_c[ACC_WIDTH-1] ? ACC_WIDTH'(-eq_c) : ACC_WIDTH'(eq_c);
    low_c    = eq_abs_c < ACC_WIDTH'(margin_i);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; the last warm-up sample moves to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (en_i) state_d = ST_WARMUP;
      ST_WARMUP: if (adc_valid_i && (warm_q == WARM_W'(N_TAPS - 1))) state_d = ST_RUN;
      ST_RUN:    state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    if (!en_i) state_d = ST_IDLE;
  end

  // FSM controls for the datapath.
  always_comb begin
    accept_c = 1'b0;
    emit_c   = 1'b0;
    clear_c  = 1'b0;
    if (!en_i) begin
      clear_c = 1'b1;
    end else begin
      case (state_q)
        ST_WARMUP: accept_c = adc_valid_i;
        ST_RUN: begin
          accept_c = adc_valid_i;
          emit_c   = adc_valid_i;
        end
        default:   clear_c = 1'b1;
      endcase
    end
  end

  // Tap register file; out-of-range addresses match no entry.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      offset_q <= '0;
      for (int k = 0; k < N_TAPS; k++) post_q[k] <= '0;
    end else if (tap_wr_i) begin
      if (tap_addr_i == ADDR_W'(OFFSET_ADDR)) offset_q <= tap_data_i;
      for (int k = 0; k < N_TAPS; k++) begin
        if (tap_addr_i == ADDR_W'(k + 1)) post_q[k] <= tap_data_i;
      end
    end
  end

  // History, warm-up count, output registers and margin counter.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      hist_q      <= '0;
      warm_q      <= '0;
      bit_valid_q <= 1'b0;
      bit_q       <= 1'b0;
      eq_q        <= '0;
      cnt_q       <= '0;
    end else begin
      bit_valid_q <= emit_c;
      if (clear_c) begin
        hist_q <= '0;
        warm_q <= '0;
        cnt_q  <= '0;
      end else if (accept_c) begin
        hist_q <= {hist_q[N_TAPS-2:0], bit_c};
        bit_q  <= bit_c;
        eq_q   <= eq_c;
        if (state_q == ST_WARMUP) warm_q <= warm_q + WARM_W'(1);
        if (low_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bit_valid_o     = bit_valid_q;
  assign bit_o           = bit_q;
  assign eq_o            = eq_q;
  assign state_o         = state_q;
  assign lowmargin_cnt_o = cnt_q;

endmodule

// File: tb/tb_rx_dfe_slicer.sv
// Scoreboard bench for rx_dfe_slicer: expected decisions are queued when a
// sample is driven and compared when bit_valid_o fires.
module tb_rx_dfe_slicer;
  import rx_dfe_pack::*;

  localparam int unsigned N_TAPS    = 8;
  localparam int unsigned ADC_WIDTH = 8;
  localparam int unsigned TAP_WIDTH = 10;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned ACC_WIDTH = acc_width(ADC_WIDTH, TAP_WIDTH, N_TAPS);
  localparam int unsigned ADDR_W    = $clog2(N_TAPS + 1);

  logic                        clk_i;
  logic                        rstb_i;
  logic                        en_i;
  logic                        adc_valid_i;
  logic signed [ADC_WIDTH-1:0] adc_data_i;
  logic                        tap_wr_i;
  logic [ADDR_W-1:0]           tap_addr_i;
  logic signed [TAP_WIDTH-1:0] tap_data_i;
  logic [TAP_WIDTH-2:0]        margin_i;
  logic                        bit_valid_o;
  logic                        bit_o;
  logic signed [ACC_WIDTH-1:0] eq_o;
  logic [1:0]                  state_o;
  logic [CNT_WIDTH-1:0]        lowmargin_cnt_o;

  typedef struct {
    int b;
    int eq;
    int due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  rx_dfe_slicer #(
    .N_TAPS    (N_TAPS),
    .ADC_WIDTH (ADC_WIDTH),
    .TAP_WIDTH (TAP_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_i           (clk_i),
    .rstb_i          (rstb_i),
    .en_i            (en_i),
    .adc_valid_i     (adc_valid_i),
    .adc_data_i      (adc_data_i),
    .tap_wr_i        (tap_wr_i),
    .tap_addr_i      (tap_addr_i),
    .tap_data_i      (tap_data_i),
    .margin_i        (margin_i),
    .bit_valid_o     (bit_valid_o),
    .bit_o           (bit_o),
    .eq_o            (eq_o),
    .state_o         (state_o),
    .lowmargin_cnt_o (lowmargin_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the update edge.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      check("bit_valid", 32'(bit_valid_o), 1);
      check("bit", 32'(bit_o), mon_e.b);
      check("eq", eq_o, mon_e.eq);
    end else if (bit_valid_o !== 1'b0) begin
      check("unexpected_valid", 32'(bit_valid_o), 0);
    end
  end

  task automatic step(input logic vld, input int adc, input logic wr,
                      input int addr, input int data, input logic exp_v,
                      input int eb, input int ee);
    @(posedge clk_i);
    #1;
    adc_valid_i = vld;
    adc_data_i  = ADC_WIDTH'(adc);
    tap_wr_i    = wr;
    tap_addr_i  = ADDR_W'(addr);
    tap_data_i  = TAP_WIDTH'(data);
    if (exp_v) sb_q.push_back('{eb, ee, cyc + 1});
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic sample(input int adc);
    step(1'b1, adc, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic sample_x(input int adc, input int eb, input int ee);
    step(1'b1, adc, 1'b0, 0, 0, 1'b1, eb, ee);
  endtask

  task automatic wr_tap(input int addr, input int data);
    step(1'b0, 0, 1'b1, addr, data, 1'b0, 0, 0);
  endtask

  initial begin
    rstb_i      = 1'b0;
    en_i        = 1'b0;
    adc_valid_i = 1'b0;
    adc_data_i  = '0;
    tap_wr_i    = 1'b0;
    tap_addr_i  = '0;
    tap_data_i  = '0;
    margin_i    = '0;

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_state", 32'(state_o), 0);
    check("rst_valid", 32'(bit_valid_o), 0);
    check("rst_bit", 32'(bit_o), 0);
    check("rst_eq", eq_o, 0);
    check("rst_cnt", 32'(lowmargin_cnt_o), 0);
    rstb_i = 1'b1;
    idle();
    check("idle_state", 32'(state_o), 0);

    // Zero taps: warm-up then plain slicing
    en_i = 1'b1;
    idle();
    check("warmup_state", 32'(state_o), 1);
    repeat (N_TAPS) sample(1);
    idle();
    check("run_state", 32'(state_o), 2);
    sample_x(5, 1, 5);
    sample_x(-3, 0, -3);
    sample_x(0, 1, 0);
    sample_x(-128, 0, -128);

    // ISI cancellation with tap[1] = 20
    wr_tap(1, 20);
    sample_x(100, 1, 120);
    sample_x(10, 0, -10);
    sample_x(10, 1, 30);

    // Same-cycle offset write uses the old offset
    wr_tap(1, 0);
    step(1'b1, 30, 1'b1, 0, 50, 1'b1, 1, 30);
    sample_x(30, 0, -20);

    // Out-of-range tap address is ignored
    wr_tap(9, 100);
    sample_x(60, 1, 10);

    // Low-margin counting and saturation
    wr_tap(0, 0);
    idle();
    check("cnt_before_margin", 32'(lowmargin_cnt_o), 0);
    margin_i = 4;
    repeat (3) sample_x(2, 1, 2);
    sample_x(4, 1, 4);
    sample_x(-4, 0, -4);
    idle();
    check("cnt_three", 32'(lowmargin_cnt_o), 3);
    sample_x(-3, 0, -3);
    idle();
    check("cnt_four", 32'(lowmargin_cnt_o), 4);
    repeat (16) sample_x(2, 1, 2);
    idle();
    check("cnt_saturated", 32'(lowmargin_cnt_o), 15);

    // Enable drop: IDLE, counter cleared, taps retained across re-warm-up
    wr_tap(0, 5);
    wr_tap(3, 16);
    idle();
    en_i = 1'b0;
    idle();
    check("drop_state", 32'(state_o), 0);
    check("drop_valid", 32'(bit_valid_o), 0);
    check("drop_cnt", 32'(lowmargin_cnt_o), 0);
    en_i = 1'b1;
    idle();
    check("reen_state", 32'(state_o), 1);
    repeat (N_TAPS) sample(100);
    idle();
    check("reen_run_state", 32'(state_o), 2);
    sample_x(0, 0, -21);
    sample_x(0, 0, -21);
    sample_x(30, 1, 9);
    sample_x(-10, 1, 1);
    idle();
    check("cnt_after_reen", 32'(lowmargin_cnt_o), 1);

    // Asynchronous reset mid-RUN, between clock edges
    @(posedge clk_i);
    #2;
    rstb_i = 1'b0;
    #1;
    check("async_rst_state", 32'(state_o), 0);
    check("async_rst_valid", 32'(bit_valid_o), 0);
    check("async_rst_bit", 32'(bit_o), 0);
    check("async_rst_eq", eq_o, 0);
    check("async_rst_cnt", 32'(lowmargin_cnt_o), 0);
    @(posedge clk_i);
    #1;
    rstb_i = 1'b1;
    idle();
    check("post_rst_state", 32'(state_o), 1);
    repeat (N_TAPS) sample(100);
    sample_x(0, 1, 0);
    sample_x(-1, 0, -1);
    idle();
    idle();
    idle();
    check("scoreboard_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
